wb_dest_pipe: RTL and testbench

// Parametrised write-back destination tracker for the 16-bit pipelined CPU.

---
 rtl/wb_dest_pipe.sv | 121 ++++++++++++
 tb/tb_wb_dest_pipe.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_dest_pipe.sv
// Write-back destination tracker: decodes the WBReg selector into a register index and
// carries {valid, idx} through a STAGES-deep pipe, exposing per-stage source matches.
module wb_dest_pipe #(
  parameter int STAGES = 3,
  parameter int IDX_W  = 4,
  parameter int SEL_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [SEL_W-1:0]  wb_sel,
  input  logic [IDX_W-1:0]  regx,
  input  logic [IDX_W-1:0]  regy,
  input  logic [IDX_W-1:0]  regz,
  input  logic              stall,
  input  logic              flush,
  input  logic [IDX_W-1:0]  src_a,
  input  logic [IDX_W-1:0]  src_b,
  output logic              wr_en,
  output logic [IDX_W-1:0]  wr_idx,
  output logic [STAGES-1:0] match_a,
  output logic [STAGES-1:0] match_b,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  localparam logic [IDX_W-1:0] IDX_NONE = IDX_W'(4'hF);
  localparam logic [SEL_W-1:0] SEL_RX   = SEL_W'(8'h05);
  localparam logic [SEL_W-1:0] SEL_RY   = SEL_W'(8'h06);
  localparam logic [SEL_W-1:0] SEL_RZ   = SEL_W'(8'h07);
  localparam logic [SEL_W-1:0] SEL_IN   = SEL_W'(8'h08);
  localparam logic [SEL_W-1:0] SEL_SP   = SEL_W'(8'h09);
  localparam logic [SEL_W-1:0] SEL_T    = SEL_W'(8'h0A);
  localparam logic [SEL_W-1:0] SEL_R5   = SEL_W'(8'h29);

  logic [IDX_W-1:0]  dec_idx;
  logic              entry_valid;
  logic [IDX_W-1:0]  entry_idx;

  logic [STAGES-1:0] valid_q, valid_d;
  logic [IDX_W-1:0]  idx_q [STAGES];
  logic [IDX_W-1:0]  idx_d [STAGES];

  always_comb begin
    dec_idx = IDX_NONE;
    case (wb_sel)
      SEL_RX:  dec_idx = regx;
      SEL_RY:  dec_idx = regy;
      SEL_RZ:  dec_idx = regz;
      SEL_IN:  dec_idx = IDX_W'(4'h9);
      SEL_SP:  dec_idx = IDX_W'(4'hA);
      SEL_T:   dec_idx = IDX_W'(4'hB);
      SEL_R5:  dec_idx = IDX_W'(4'h5);
      default: dec_idx = IDX_NONE;
    endcase
  end

  // An entry decoding to the EMPTY index is a non-writing instruction, treated as a bubble.
  assign entry_valid = in_valid && (dec_idx != IDX_NONE);
  assign entry_idx   = entry_valid ? dec_idx : IDX_NONE;

  always_comb begin
    valid_d = valid_q;
    for (int k = 0; k < STAGES; k++) idx_d[k] = idx_q[k];

    if (flush) begin
      valid_d[0] = 1'b0;
      idx_d[0]   = IDX_NONE;
    end else if (!stall) begin
      valid_d[0] = entry_valid;
      idx_d[0]   = entry_idx;
    end

    if (stall) begin
      valid_d[1] = 1'b0;
      idx_d[1]   = IDX_NONE;
    end else begin
      valid_d[1] = valid_q[0];
      idx_d[1]   = idx_q[0];
    end

    for (int k = 2; k < STAGES; k++) begin
      valid_d[k] = valid_q[k-1];
      idx_d[k]   = idx_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) idx_q[k] <= IDX_NONE;
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < STAGES; k++) idx_q[k] <= idx_d[k];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_match
      assign match_a[gi] = valid_q[gi] && (idx_q[gi] == src_a);
      assign match_b[gi] = valid_q[gi] && (idx_q[gi] == src_b);
    end
  endgenerate

  // Scan oldest to youngest so the youngest match overwrites; stage 3 and beyond share code 3.
  function automatic logic [1:0] youngest(input logic [STAGES-1:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (m[k]) r = (k >= 2) ? 2'd3 : 2'(k + 1);
    end
    return r;
  endfunction

  assign fwd_a  = youngest(match_a);
  assign fwd_b  = youngest(match_b);
  assign wr_en  = valid_q[STAGES-1];
  assign wr_idx = idx_q[STAGES-1];

endmodule

// File: tb/tb_wb_dest_pipe.sv
// Self-checking bench for wb_dest_pipe: directed scenarios plus randomized traffic
// compared against an in-flight list model of destination entries.
module tb_wb_dest_pipe;

  localparam int S = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] wb_sel = 8'h00;
  logic [3:0] regx = 4'h0, regy = 4'h0, regz = 4'h0;
  logic       stall = 1'b0, flush = 1'b0;
  logic [3:0] src_a = 4'h0, src_b = 4'h0;
  logic       wr_en;
  logic [3:0] wr_idx;
  logic [S-1:0] match_a, match_b;
  logic [1:0] fwd_a, fwd_b;

  int n_pass  = 0;
  int n_total = 0;

  // Model: slot k (1..S) holds the destination that sits k edges away from decode.
  bit         m_valid [1:S];
  logic [3:0] m_idx   [1:S];

  wb_dest_pipe #(.STAGES(S), .IDX_W(4), .SEL_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .wb_sel(wb_sel),
    .regx(regx), .regy(regy), .regz(regz), .stall(stall), .flush(flush),
    .src_a(src_a), .src_b(src_b), .wr_en(wr_en), .wr_idx(wr_idx),
    .match_a(match_a), .match_b(match_b), .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] ref_dest(input logic [7:0] sel, input logic [3:0] x,
                                          input logic [3:0] y, input logic [3:0] z);
    case (sel)
      8'h05: return x;
      8'h06: return y;
      8'h07: return z;
      8'h08: return 4'h9;
      8'h09: return 4'hA;
      8'h0A: return 4'hB;
      8'h29: return 4'h5;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [S-1:0] exp_match(input logic [3:0] src);
    logic [S-1:0] m;
    m = '0;
    for (int k = 1; k <= S; k++) m[k-1] = m_valid[k] && (m_idx[k] == src);
    return m;
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [3:0] src);
    for (int k = 1; k <= S; k++) begin
      if (m_valid[k] && m_idx[k] == src) return (k >= 3) ? 2'd3 : 2'(k);
    end
    return 2'd0;
  endfunction

  task automatic model_clear();
    for (int k = 1; k <= S; k++) begin
      m_valid[k] = 1'b0;
      m_idx[k]   = 4'hF;
    end
  endtask

  // Advance one clock edge, moving the model by the rules the design must obey.
  task automatic tick();
    logic [3:0] d;
    bit         dv;
    @(posedge clk);
    if (!rst) begin
      model_clear();
    end else begin
      d  = ref_dest(wb_sel, regx, regy, regz);
      dv = in_valid && (d != 4'hF);
      for (int k = S; k >= 3; k--) begin
        m_valid[k] = m_valid[k-1];
        m_idx[k]   = m_idx[k-1];
      end
      if (stall) begin
        m_valid[2] = 1'b0; m_idx[2] = 4'hF;
      end else begin
        m_valid[2] = m_valid[1]; m_idx[2] = m_idx[1];
      end
      if (flush) begin
        m_valid[1] = 1'b0; m_idx[1] = 4'hF;
      end else if (!stall) begin
        m_valid[1] = dv; m_idx[1] = dv ? d : 4'hF;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_clear();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; wb_sel = 8'h05; regx = 4'($urandom_range(0, 14));
      stall = 1'($urandom); flush = 1'b0;
      src_a = regx; src_b = 4'hF;
      tick();
      n_total++;
      if (wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b expected 0", wr_en);
      else n_pass++;
      n_total++;
      if (wr_idx !== 4'hF) $display("FAIL reset_wr_idx: got %h expected f", wr_idx);
      else n_pass++;
      n_total++;
      if (match_a !== '0 || fwd_a !== 2'd0)
        $display("FAIL reset_match: got match_a=%b fwd_a=%0d expected 000/0", match_a, fwd_a);
      else n_pass++;
    end
    in_valid = 1'b0; stall = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if (wr_en !== 1'b0 || match_a !== '0)
        $display("FAIL post_reset_idle: got wr_en=%b match_a=%b expected 0/000", wr_en, match_a);
      else n_pass++;
    end
  endtask

  task automatic test_decode_sweep();
    logic [7:0] sels [9];
    logic [3:0] eidx [9];
    logic       een  [9];
    sels = '{8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h29, 8'h0B, 8'h33};
    eidx = '{4'h2, 4'h3, 4'h4, 4'h9, 4'hA, 4'hB, 4'h5, 4'hF, 4'hF};
    een  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    regx = 4'h2; regy = 4'h3; regz = 4'h4;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; wb_sel = sels[i];
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      n_total++;
      if (wr_en !== een[i] || (een[i] && wr_idx !== eidx[i]))
        $display("FAIL decode_%h: got wr_en=%b wr_idx=%h expected %b/%h",
                 sels[i], wr_en, wr_idx, een[i], eidx[i]);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    logic exp_en [5];
    exp_en = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tick(); tick(); tick();
    in_valid = 1'b1; wb_sel = 8'h05; regx = 4'h1; src_a = 4'h1;
    for (int e = 0; e < 5; e++) begin
      if (e == 1) begin in_valid = 1'b0; stall = 1'b1; end
      if (e == 3) stall = 1'b0;
      tick();
      n_total++;
      if (wr_en !== exp_en[e] || (exp_en[e] && wr_idx !== 4'h1))
        $display("FAIL stall_edge%0d: got wr_en=%b wr_idx=%h expected %b/1",
                 e + 1, wr_en, wr_idx, exp_en[e]);
      else n_pass++;
      if (e == 1) begin
        n_total++;
        if (match_a !== 3'b001 || fwd_a !== 2'd1)
          $display("FAIL stall_hold: got match_a=%b fwd_a=%0d expected 001/1", match_a, fwd_a);
        else n_pass++;
      end
    end
  endtask

  task automatic test_flush();
    bit sp_written = 1'b0;
    bit t_written  = 1'b0;
    tick(); tick(); tick();
    in_valid = 1'b1; wb_sel = 8'h09;
    tick();
    flush = 1'b1; stall = 1'b1; in_valid = 1'b0;
    tick();
    n_total++;
    if (match_a !== 3'b000 || wr_en !== 1'b0)
      $display("FAIL flush_kill: got match_a=%b wr_en=%b expected 000/0", match_a, wr_en);
    else n_pass++;
    flush = 1'b0; stall = 1'b0;
    in_valid = 1'b1; wb_sel = 8'h0A;
    for (int e = 0; e < 4; e++) begin
      tick();
      in_valid = 1'b0;
      if (wr_en && wr_idx == 4'hA) sp_written = 1'b1;
      if (wr_en && wr_idx == 4'hB && e == 2) t_written = 1'b1;
    end
    n_total++;
    if (sp_written !== 1'b0) $display("FAIL flush_sp_write: got 1 expected 0");
    else n_pass++;
    n_total++;
    if (t_written !== 1'b1) $display("FAIL flush_follow_write: got 0 expected 1");
    else n_pass++;
  endtask

  task automatic test_forwarding();
    tick(); tick(); tick();
    src_a = 4'h3; src_b = 4'h7;
    in_valid = 1'b1; wb_sel = 8'h07; regz = 4'h3;
    tick();
    wb_sel = 8'h05; regx = 4'h3;
    tick();
    n_total++;
    if (match_a !== 3'b011 || fwd_a !== 2'd1)
      $display("FAIL fwd_young: got match_a=%b fwd_a=%0d expected 011/1", match_a, fwd_a);
    else n_pass++;
    n_total++;
    if (match_b !== 3'b000 || fwd_b !== 2'd0)
      $display("FAIL fwd_nomatch_b: got match_b=%b fwd_b=%0d expected 000/0", match_b, fwd_b);
    else n_pass++;
    in_valid = 1'b0;
    tick();
    n_total++;
    if (match_a !== 3'b110 || fwd_a !== 2'd2)
      $display("FAIL fwd_stage2: got match_a=%b fwd_a=%0d expected 110/2", match_a, fwd_a);
    else n_pass++;
    tick();
    n_total++;
    if (match_a !== 3'b100 || fwd_a !== 2'd3 || wr_en !== 1'b1 || wr_idx !== 4'h3)
      $display("FAIL fwd_stage3: got match_a=%b fwd_a=%0d wr=%b/%h expected 100/3 1/3",
               match_a, fwd_a, wr_en, wr_idx);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [7:0] pool [10];
    pool = '{8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h29, 8'h0B, 8'h33, 8'h00};
    for (int i = 0; i < 150; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      wb_sel   = ($urandom_range(0, 7) == 0) ? 8'($urandom) : pool[$urandom_range(0, 9)];
      regx = 4'($urandom_range(0, 7)); regy = 4'($urandom_range(0, 7));
      regz = 4'($urandom_range(0, 7));
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 7) == 0);
      tick();
      src_a = 4'($urandom_range(0, 11)); src_b = 4'($urandom_range(0, 11));
      #1;
      n_total++;
      if (wr_en !== m_valid[S]) $display("FAIL rnd%0d_wr_en: got %b expected %b", i, wr_en, m_valid[S]);
      else n_pass++;
      n_total++;
      if (wr_idx !== m_idx[S]) $display("FAIL rnd%0d_wr_idx: got %h expected %h", i, wr_idx, m_idx[S]);
      else n_pass++;
      n_total++;
      if (match_a !== exp_match(src_a))
        $display("FAIL rnd%0d_match_a: got %b expected %b", i, match_a, exp_match(src_a));
      else n_pass++;
      n_total++;
      if (match_b !== exp_match(src_b))
        $display("FAIL rnd%0d_match_b: got %b expected %b", i, match_b, exp_match(src_b));
      else n_pass++;
      n_total++;
      if (fwd_a !== exp_fwd(src_a)) $display("FAIL rnd%0d_fwd_a: got %0d expected %0d", i, fwd_a, exp_fwd(src_a));
      else n_pass++;
      n_total++;
      if (fwd_b !== exp_fwd(src_b)) $display("FAIL rnd%0d_fwd_b: got %0d expected %0d", i, fwd_b, exp_fwd(src_b));
      else n_pass++;
    end
    stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_midstream_reset();
    bit leaked = 1'b0;
    tick(); tick(); tick();
    regx = 4'h6; regy = 4'h7; regz = 4'h8;
    in_valid = 1'b1;
    wb_sel = 8'h05; tick();
    wb_sel = 8'h06; tick();
    wb_sel = 8'h07; tick();
    in_valid = 1'b0;
    n_total++;
    if (wr_en !== 1'b1 || wr_idx !== 4'h6)
      $display("FAIL mid_pre: got wr_en=%b wr_idx=%h expected 1/6", wr_en, wr_idx);
    else n_pass++;
    src_a = 4'h8;
    #1 rst = 1'b0;
    model_clear();
    #1;
    n_total++;
    if (wr_en !== 1'b0 || wr_idx !== 4'hF)
      $display("FAIL mid_async: got wr_en=%b wr_idx=%h expected 0/f", wr_en, wr_idx);
    else n_pass++;
    n_total++;
    if (match_a !== 3'b000 || fwd_a !== 2'd0)
      $display("FAIL mid_match: got match_a=%b fwd_a=%0d expected 000/0", match_a, fwd_a);
    else n_pass++;
    #1 rst = 1'b1;
    for (int e = 0; e < 4; e++) begin
      tick();
      if (wr_en) leaked = 1'b1;
    end
    n_total++;
    if (leaked !== 1'b0) $display("FAIL mid_no_write: got 1 expected 0");
    else n_pass++;
  endtask

  initial begin
    model_clear();
    test_reset();
    test_decode_sweep();
    test_stall();
    test_flush();
    test_forwarding();
    test_random();
    test_midstream_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
